serial_mod_rem: RTL and testbench
=================================

# serial_mod_rem

Parametrised serial remainder engine. It consumes a number one DW-bit digit per cycle and tracks the running remainder modulo a compile-time constant MOD. On the last digit it emits a registered result: remainder, divisible flag and digit count. It sits on a digit-stream interface as the generalised successor of the team's fixed divide-by-3 bit-serial detector, for divisibility checks and checksum pre-filters.

## Interface
- MOD, default 3: modulus, legal range 2..255.
- DW, default 1: digit width in bits; digits are consumed at radix 2^DW; legal range 1..8.
- LENW, default 8: width of the digit-count output.
- RW, derived as clog2(MOD): remainder width; must not be overridden.
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous abort; discards any word in progress.
- in_valid  input  1  in_data/in_last are valid this cycle.
- in_data  input  DW  digit value; any value 0..2^DW-1 is legal, including values >= MOD.
- in_last  input  1  final digit of the current word.
- run_rem  output  RW  running remainder of the digits accepted so far.
- run_div  output  1  1 when a word is in progress and run_rem==0.
- res_valid  output  1  one-cycle pulse: the result is updated.
- res_rem  output  RW  remainder of the last completed word.
- res_div  output  1  res_rem==0.
- res_len  output  LENW  digits in the last completed word; saturates at 2^LENW-1.
- lsb_first  input  1  present only with SERIAL_MOD_LSB_FIRST_EN; see Configuration.

## Operation
- FSM states:
  - IDLE: no word open.
  - ACC: a word is open.
- Transitions:
  - IDLE→ACC on in_valid && !in_last.
  - IDLE→IDLE on in_valid && in_last; this is a single-digit word, and a result is produced.
  - ACC→IDLE on in_valid && in_last.
  - Any state→IDLE on clr.
- The first digit of a word starts from r=0, not from the stale remainder.
- MSB-first update: r' = (r*2^DW + d) mod MOD.
  - The intermediate value is RW+DW bits wide.
  - The reduction is `%` by the constant MOD, which is combinational.
- Digit counter cnt: set to 1 on the first digit, then incremented per digit, saturating at 2^LENW-1.
- On the accepted in_last digit:
  - res_rem and res_len are loaded with the updated r and cnt.
  - res_div is loaded with (updated r == 0).
  - res_valid pulses.
- res_* hold their value until the next completed word.
- In IDLE, run_rem=0 and run_div=0. An empty word is never reported as divisible.
- in_valid low means the state holds; gaps between digits are allowed.
- clr has priority over in_valid. When both are asserted, the digit is dropped and res_valid stays 0.
- Reset values:
  - FSM=IDLE, r=0, cnt=0.
  - run_rem=0, run_div=0.
  - res_valid=0, res_rem=0, res_div=0, res_len=0.
- Reset mid-word discards the word with no result.

## Timing
- Throughput: one digit per cycle, no backpressure.
- run_rem/run_div reflect the digits accepted up to and including the previous clock edge.
- Latency: res_valid rises in the cycle after the edge that accepts the in_last digit, i.e. 1 cycle.
- Back-to-back words: the first digit of the next word may arrive in the cycle immediately after in_last, with no bubble.
- Asynchronous rst asserted at any time forces the reset values immediately. Release is synchronised by the integrator.

## Configuration
- SERIAL_MOD_LSB_FIRST_EN defined:
  - Adds the lsb_first port, which is sampled on the first digit of each word and held for the whole word.
  - Adds a weight register w, which is 1 at word start.
  - When lsb_first=1: r' = (r + d*w) mod MOD and w' = (w*2^DW) mod MOD.
  - When lsb_first=0: MSB-first behaviour is unchanged.
- SERIAL_MOD_LSB_FIRST_EN undefined:
  - No lsb_first port and no weight register.
  - MSB-first only.

## Structure
- Package serial_mod_pkg holds:
  - the state enum (IDLE, ACC);
  - a clog2 function;
  - the MOD/DW legality-check constants.
- Sub-module serial_mod_step: purely combinational next-remainder function (r, d, w, mode → r', w'), parametrised on MOD and DW.
- serial_mod_rem owns the FSM, the counter and the result registers.

## Test plan
- MOD=3, DW=1, digits 1,1,0 (6), in_last on the third digit → res_valid pulse, res_rem=0, res_div=1, res_len=3.
- MOD=3, DW=1, digits 1,0,1,1 (11) → res_rem=2, res_div=0. run_rem sequence after each digit: 1,2,2,2.
- MOD=5, DW=4, digits 0xF,0xF (255), with an in_valid gap between them → res_rem=0, res_div=1, res_len=2. The next word 0x7 (in_last) arrives with no bubble → res_rem=2, res_len=1.
- clr together with the in_last digit of a word in progress → no res_valid, previous res_* unchanged, run_rem=0, FSM in IDLE. Also assert rst mid-word → all outputs return to 0 immediately.
- LENW=2 with a 5-digit word → res_len=3, i.e. saturated.
- With SERIAL_MOD_LSB_FIRST_EN, MOD=3, DW=1, lsb_first=1, digits 1,1,0,1 (11) → res_rem=2. The same digits with lsb_first=0 (13) → res_rem=1.

Source files
------------

// File: rtl/serial_mod_pkg.sv
// rtl/serial_mod_pkg.sv - shared types, width helper and parameter limits for serial_mod_rem
package serial_mod_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  localparam int MOD_MIN = 2;
  localparam int MOD_MAX = 255;
  localparam int DW_MIN  = 1;
  localparam int DW_MAX  = 8;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  function automatic bit params_legal(input int mod_v, input int dw_v);
    return (mod_v >= MOD_MIN) && (mod_v <= MOD_MAX) && (dw_v >= DW_MIN) && (dw_v <= DW_MAX);
  endfunction

endpackage

// File: rtl/serial_mod_step.sv
// rtl/serial_mod_step.sv - combinational next-remainder step; LSB-first weight path under SERIAL_MOD_LSB_FIRST_EN
module serial_mod_step
  import serial_mod_pkg::*;
#(
  parameter int  MOD = 3,
  parameter int  DW  = 1,
  localparam int RW  = clog2(MOD)
) (
  input  logic [RW-1:0] r_in,
  input  logic [DW-1:0] d_in,
`ifdef SERIAL_MOD_LSB_FIRST_EN
  input  logic [RW-1:0] w_in,
  input  logic          lsb_mode,
  output logic [RW-1:0] w_out,
`endif
  output logic [RW-1:0] r_out
);

  // One spare bit so the LSB-first sum r + d*w cannot overflow.
  localparam int XW = RW + DW + 1;
  localparam logic [XW-1:0] MOD_X = XW'(MOD);

  logic [XW-1:0] msb_x;

  // Concatenation is r*2^DW + d without a multiplier.
  assign msb_x = XW'({r_in, d_in});

`ifdef SERIAL_MOD_LSB_FIRST_EN
  logic [XW-1:0] lsb_x;
  logic [XW-1:0] w_x;

  assign lsb_x = XW'(r_in) + XW'(d_in) * XW'(w_in);
  assign w_x   = XW'({w_in, {DW{1'b0}}});

  always_comb begin
    r_out = RW'(msb_x % MOD_X);
    if (lsb_mode) r_out = RW'(lsb_x % MOD_X);
    w_out = RW'(w_x % MOD_X);
  end
`else
  always_comb begin
    r_out = RW'(msb_x % MOD_X);
  end
`endif

endmodule

// File: rtl/serial_mod_rem.sv
// rtl/serial_mod_rem.sv - serial remainder engine (FSM, digit counter, result registers); option SERIAL_MOD_LSB_FIRST_EN
module serial_mod_rem
  import serial_mod_pkg::*;
#(
  parameter int  MOD  = 3,
  parameter int  DW   = 1,
  parameter int  LENW = 8,
  localparam int RW   = clog2(MOD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic            in_last,
`ifdef SERIAL_MOD_LSB_FIRST_EN
  input  logic            lsb_first,
`endif
  output logic [RW-1:0]   run_rem,
  output logic            run_div,
  output logic            res_valid,
  output logic [RW-1:0]   res_rem,
  output logic            res_div,
  output logic [LENW-1:0] res_len
);

  generate
    if (!params_legal(MOD, DW)) begin : g_param_check
      $error("serial_mod_rem: MOD must be 2..255 and DW 1..8");
    end
  endgenerate

  localparam logic [LENW-1:0] CNT_MAX = '1;

  state_e          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic            res_valid_q, res_valid_d;
  logic [RW-1:0]   res_rem_q, res_rem_d;
  logic            res_div_q, res_div_d;
  logic [LENW-1:0] res_len_q, res_len_d;

  logic            word_open;
  logic [RW-1:0]   r_base;
  logic [RW-1:0]   r_step;
  logic [LENW-1:0] cnt_next;

  assign word_open = (state_q == ACC);
  // A new word always starts from zero, never from a leftover remainder.
  assign r_base    = word_open ? r_q : '0;
  assign cnt_next  = !word_open ? LENW'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);

`ifdef SERIAL_MOD_LSB_FIRST_EN
  logic [RW-1:0] w_q, w_d;
  logic          lsb_q, lsb_d;
  logic [RW-1:0] w_base;
  logic [RW-1:0] w_step;
  logic          mode;

  assign w_base = word_open ? w_q : RW'(1);
  assign mode   = word_open ? lsb_q : lsb_first;

  serial_mod_step #(.MOD(MOD), .DW(DW)) u_step (
    .r_in     (r_base),
    .d_in     (in_data),
    .w_in     (w_base),
    .lsb_mode (mode),
    .w_out    (w_step),
    .r_out    (r_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q   <= RW'(1);
      lsb_q <= 1'b0;
    end else begin
      w_q   <= w_d;
      lsb_q <= lsb_d;
    end
  end

  always_comb begin
    w_d   = w_q;
    lsb_d = lsb_q;
    if (!clr && in_valid && !in_last) begin
      w_d   = w_step;
      lsb_d = mode;
    end
  end
`else
  serial_mod_step #(.MOD(MOD), .DW(DW)) u_step (
    .r_in  (r_base),
    .d_in  (in_data),
    .r_out (r_step)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_rem_q   <= '0;
      res_div_q   <= 1'b0;
      res_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_rem_q   <= res_rem_d;
      res_div_q   <= res_div_d;
      res_len_q   <= res_len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    res_valid_d = 1'b0;
    res_rem_d   = res_rem_q;
    res_div_d   = res_div_q;
    res_len_d   = res_len_q;
    if (clr) begin
      state_d = IDLE;
      r_d     = '0;
      cnt_d   = '0;
    end else if (in_valid) begin
      if (in_last) begin
        state_d     = IDLE;
        r_d         = '0;
        cnt_d       = '0;
        res_valid_d = 1'b1;
        res_rem_d   = r_step;
        res_div_d   = (r_step == '0);
        res_len_d   = cnt_next;
      end else begin
        state_d = ACC;
        r_d     = r_step;
        cnt_d   = cnt_next;
      end
    end
  end

  assign run_rem   = word_open ? r_q : '0;
  assign run_div   = word_open && (r_q == '0);
  assign res_valid = res_valid_q;
  assign res_rem   = res_rem_q;
  assign res_div   = res_div_q;
  assign res_len   = res_len_q;

endmodule

// File: tb/tb_serial_mod_rem.sv
// tb/tb_serial_mod_rem.sv - scoreboard bench for serial_mod_rem (MOD=3/DW=1 and MOD=5/DW=4/LENW=2); honours SERIAL_MOD_LSB_FIRST_EN
module tb_serial_mod_rem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       clr_a, vld_a, last_a, lsb_a;
  logic [0:0] dat_a;
  logic [1:0] run_rem_a, res_rem_a;
  logic       run_div_a, res_valid_a, res_div_a;
  logic [7:0] res_len_a;

  logic       clr_b, vld_b, last_b, lsb_b;
  logic [3:0] dat_b;
  logic [2:0] run_rem_b, res_rem_b;
  logic       run_div_b, res_valid_b, res_div_b;
  logic [1:0] res_len_b;

  serial_mod_rem #(.MOD(3), .DW(1), .LENW(8)) u_dut_a (
    .clk(clk), .rst(rst), .clr(clr_a), .in_valid(vld_a), .in_data(dat_a), .in_last(last_a),
`ifdef SERIAL_MOD_LSB_FIRST_EN
    .lsb_first(lsb_a),
`endif
    .run_rem(run_rem_a), .run_div(run_div_a), .res_valid(res_valid_a),
    .res_rem(res_rem_a), .res_div(res_div_a), .res_len(res_len_a)
  );

  serial_mod_rem #(.MOD(5), .DW(4), .LENW(2)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .in_valid(vld_b), .in_data(dat_b), .in_last(last_b),
`ifdef SERIAL_MOD_LSB_FIRST_EN
    .lsb_first(lsb_b),
`endif
    .run_rem(run_rem_b), .run_div(run_div_b), .res_valid(res_valid_b),
    .res_rem(res_rem_b), .res_div(res_div_b), .res_len(res_len_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int rem;
    int len;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  longint unsigned val_a, val_b;
  int  cnt_a = 0, cnt_b = 0;
  bit  wlsb_a, wlsb_b;
  int  last_rem_a = 0, last_len_a = 0;

  function automatic longint unsigned model_add(input longint unsigned val, input int pos,
                                                input int dw, input int d, input bit lsb);
    if (lsb) return val + (longint'(d) << (dw * pos));
    return (val << dw) + longint'(d);
  endfunction

  task automatic send_a(input int d, input bit last, input int gap);
    if (cnt_a == 0) begin
      val_a  = 0;
      wlsb_a = lsb_a;
    end
    val_a = model_add(val_a, cnt_a, 1, d, wlsb_a);
    cnt_a++;
    vld_a  = 1'b1;
    dat_a  = d[0:0];
    last_a = last;
    if (last) begin
      last_rem_a = int'(val_a % 3);
      last_len_a = (cnt_a > 255) ? 255 : cnt_a;
      q_a.push_back('{rem: last_rem_a, len: last_len_a});
    end
    @(negedge clk);
    vld_a  = 1'b0;
    last_a = 1'b0;
    if (last) begin
      cnt_a = 0;
      check_eq("a_res_valid_latency", res_valid_a, 1);
      check_eq("a_run_rem_idle", run_rem_a, 0);
      check_eq("a_run_div_idle", run_div_a, 0);
    end else begin
      check_eq("a_run_rem", run_rem_a, val_a % 3);
      check_eq("a_run_div", run_div_a, (val_a % 3) == 0);
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_b(input int d, input bit last, input int gap);
    if (cnt_b == 0) begin
      val_b  = 0;
      wlsb_b = lsb_b;
    end
    val_b = model_add(val_b, cnt_b, 4, d, wlsb_b);
    cnt_b++;
    vld_b  = 1'b1;
    dat_b  = d[3:0];
    last_b = last;
    if (last) q_b.push_back('{rem: int'(val_b % 5), len: (cnt_b > 3) ? 3 : cnt_b});
    @(negedge clk);
    vld_b  = 1'b0;
    last_b = 1'b0;
    if (last) begin
      cnt_b = 0;
      check_eq("b_res_valid_latency", res_valid_b, 1);
      check_eq("b_run_rem_idle", run_rem_b, 0);
    end else begin
      check_eq("b_run_rem", run_rem_b, val_b % 5);
      check_eq("b_run_div", run_div_b, (val_b % 5) == 0);
    end
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b0) begin
      if (res_valid_a === 1'b1) begin
        if (q_a.size() == 0) check_eq("a_unexpected_res_valid", 1, 0);
        else begin
          e = q_a.pop_front();
          check_eq("a_res_rem", res_rem_a, e.rem);
          check_eq("a_res_div", res_div_a, e.rem == 0);
          check_eq("a_res_len", res_len_a, e.len);
        end
      end
      if (res_valid_b === 1'b1) begin
        if (q_b.size() == 0) check_eq("b_unexpected_res_valid", 1, 0);
        else begin
          e = q_b.pop_front();
          check_eq("b_res_rem", res_rem_b, e.rem);
          check_eq("b_res_div", res_div_b, e.rem == 0);
          check_eq("b_res_len", res_len_b, e.len);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a_outs"}, {run_rem_a, run_div_a, res_valid_a, res_rem_a, res_div_a, res_len_a}, 0);
    check_eq({tag, "_b_outs"}, {run_rem_b, run_div_b, res_valid_b, res_rem_b, res_div_b, res_len_b}, 0);
  endtask

  initial begin
    rst = 1'b1;
    {clr_a, vld_a, last_a, lsb_a, dat_a} = '0;
    {clr_b, vld_b, last_b, lsb_b, dat_b} = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 6 mod 3, then 11 mod 3
    send_a(1, 0, 0); send_a(1, 0, 0); send_a(0, 1, 1);
    send_a(1, 0, 0); send_a(0, 0, 0); send_a(1, 0, 0); send_a(1, 1, 1);

    // 255 mod 5 with a gap, then single-digit word with no bubble
    send_b(15, 0, 2); send_b(15, 1, 0); send_b(7, 1, 1);

    // clr together with the last digit
    send_a(1, 0, 0); send_a(0, 0, 0);
    clr_a = 1'b1; vld_a = 1'b1; dat_a = 1'b1; last_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0; vld_a = 1'b0; last_a = 1'b0;
    cnt_a = 0;
    check_eq("clr_no_res_valid", res_valid_a, 0);
    check_eq("clr_run_rem", run_rem_a, 0);
    check_eq("clr_run_div", run_div_a, 0);
    check_eq("clr_res_rem_hold", res_rem_a, last_rem_a);
    check_eq("clr_res_len_hold", res_len_a, last_len_a);
    send_a(1, 1, 1);

    // async reset mid-word
    send_a(1, 0, 0); send_a(1, 0, 0);
    send_b(3, 0, 0);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    cnt_a = 0; cnt_b = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // saturating count on LENW=2
    for (int i = 0; i < 5; i++) send_b(i + 9, i == 4, 0);
    @(negedge clk);

    for (int w = 0; w < 20; w++) begin
      int len_a, len_b;
      len_a = $urandom_range(12, 1);
      len_b = $urandom_range(12, 1);
      for (int i = 0; i < len_a; i++) send_a($urandom_range(1, 0), i == len_a - 1, $urandom_range(2, 0));
      for (int i = 0; i < len_b; i++) send_b($urandom_range(15, 0), i == len_b - 1, $urandom_range(1, 0));
    end

`ifdef SERIAL_MOD_LSB_FIRST_EN
    lsb_a = 1'b1;
    send_a(1, 0, 0); send_a(1, 0, 0); send_a(0, 0, 0); send_a(1, 1, 1);
    check_eq("lsb_first_11", last_rem_a, 2);
    lsb_a = 1'b0;
    send_a(1, 0, 0); send_a(1, 0, 0); send_a(0, 0, 0); send_a(1, 1, 1);
    lsb_b = 1'b1;
    for (int w = 0; w < 8; w++) begin
      int len_b;
      len_b = $urandom_range(10, 1);
      for (int i = 0; i < len_b; i++) send_b($urandom_range(15, 0), i == len_b - 1, 0);
    end
    lsb_b = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check_eq("a_results_outstanding", q_a.size(), 0);
    check_eq("b_results_outstanding", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
